// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op encodings, FSM states and default latencies.
// Imported by md_unit, Controller-E and Hazard.
package md_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } md_op_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO.
// Define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 7..10); otherwise they act as NOP.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [63:0]       shadow;
    logic              commit_en;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] div_s;
    logic [63:0] div_u;

    // Results are formed at the start edge; the counter only models latency.
    always_comb begin
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'b0, A} * {32'b0, B};
        div_s  = '0;
        div_u  = '0;
        if (B != '0) begin
            div_u = {A % B, A / B};
            if (A == 32'h8000_0000 && B == '1) begin
                div_s = {32'h0, 32'h8000_0000};
            end else begin
                div_s = {32'($signed(A) % $signed(B)), 32'($signed(A) / $signed(B))};
            end
        end
    end

    assign busy = (state == MD_BUSY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= MD_IDLE;
            cnt       <= '0;
            shadow    <= '0;
            commit_en <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        case (md_op_t'(op))
                            OP_MULT, OP_MULTU: begin
                                shadow    <= (md_op_t'(op) == OP_MULT) ? prod_s : prod_u;
                                commit_en <= 1'b1;
                                cnt       <= CNT_W'(MULT_CYCLES);
                                state     <= MD_BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                shadow    <= (md_op_t'(op) == OP_DIV) ? div_s : div_u;
                                // Divide by zero still occupies the unit but leaves HI/LO untouched.
                                commit_en <= (B != '0);
                                cnt       <= CNT_W'(DIV_CYCLES);
                                state     <= MD_BUSY;
                            end
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
`ifdef MD_MADD_EN
                            OP_MADD, OP_MADDU: begin
                                shadow    <= {HI, LO} + ((md_op_t'(op) == OP_MADD) ? prod_s : prod_u);
                                commit_en <= 1'b1;
                                cnt       <= CNT_W'(MULT_CYCLES);
                                state     <= MD_BUSY;
                            end
                            OP_MSUB, OP_MSUBU: begin
                                shadow    <= {HI, LO} - ((md_op_t'(op) == OP_MSUB) ? prod_s : prod_u);
                                commit_en <= 1'b1;
                                cnt       <= CNT_W'(MULT_CYCLES);
                                state     <= MD_BUSY;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                MD_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= MD_IDLE;
                        cnt   <= '0;
                        if (commit_en) begin
                            HI <= shadow[63:32];
                            LO <= shadow[31:0];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops against an arithmetic reference model.
module tb_md_unit;
    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: updates m_hi/m_lo from the architectural rules and returns busy length.
    task automatic model_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                               output int unsigned n);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        acc = {m_hi, m_lo};
        n   = 0;
        case (o)
            4'd1: begin acc = sa * sb; {m_hi, m_lo} = acc; n = 5; end
            4'd2: begin acc = ua * ub; {m_hi, m_lo} = acc; n = 5; end
            4'd3: begin
                n = 10;
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            4'd4: begin
                n = 10;
                if (b != 0) begin
                    m_lo = 32'(ua / ub); m_hi = 32'(ua % ub);
                end
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
`ifdef MD_MADD_EN
            4'd7:  begin acc = acc + longint'(sa * sb); {m_hi, m_lo} = acc; n = 5; end
            4'd8:  begin acc = acc + ua * ub;           {m_hi, m_lo} = acc; n = 5; end
            4'd9:  begin acc = acc - longint'(sa * sb); {m_hi, m_lo} = acc; n = 5; end
            4'd10: begin acc = acc - ua * ub;           {m_hi, m_lo} = acc; n = 5; end
`endif
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int unsigned n, cyc;
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        model_apply(o, a, b, n);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = $urandom; B = $urandom; op = 4'($urandom_range(0, 15));
        if (n == 0) begin
            check("busy_idle", 64'(busy), 64'(1'b0));
        end else begin
            check("hi_hold", 64'(HI), 64'(old_hi));
            check("lo_hold", 64'(LO), 64'(old_lo));
            cyc = 0;
            while (busy === 1'b1 && cyc < 64) begin
                cyc++;
                @(negedge clk);
            end
            check("busy_len", 64'(cyc), 64'(n));
        end
        check("hi", 64'(HI), 64'(m_hi));
        check("lo", 64'(LO), 64'(m_lo));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_checks = 0; n_errors = 0;
        m_hi = '0; m_lo = '0;
        reset = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_hi", 64'(HI), 64'h0);
        check("rst_lo", 64'(LO), 64'h0);
        reset = 1'b1;

        // Reset in the middle of a divide: abort, clear, and no later commit.
        run_op(4'd5, 32'h55, 32'h0);
        run_op(4'd6, 32'h66, 32'h0);
        @(negedge clk);
        op = 4'd3; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_div_busy", 64'(busy), 64'(1'b1));
        reset = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'(1'b0));
        check("async_rst_hi", 64'(HI), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (15) @(negedge clk);
        check("abort_busy", 64'(busy), 64'(1'b0));
        check("abort_hi", 64'(HI), 64'h0);
        check("abort_lo", 64'(LO), 64'h0);

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi_k", 64'(HI), 64'hFFFF_FFFF);
        check("mult_lo_k", 64'(LO), 64'hFFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3);
        check("multu_hi_k", 64'(HI), 64'h2);
        check("multu_lo_k", 64'(LO), 64'hFFFF_FFFA);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_k", 64'(LO), 64'hFFFF_FFFD);
        check("div_hi_k", 64'(HI), 64'hFFFF_FFFF);
        run_op(4'd4, 32'd7, 32'd2);
        check("divu_lo_k", 64'(LO), 64'h3);
        check("divu_hi_k", 64'(HI), 64'h1);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf_lo_k", 64'(LO), 64'h8000_0000);
        check("divovf_hi_k", 64'(HI), 64'h0);
        run_op(4'd5, 32'h11, 32'h0);
        run_op(4'd6, 32'h22, 32'h0);
        run_op(4'd3, 32'd1234, 32'h0);
        check("div0_hi_k", 64'(HI), 64'h11);
        check("div0_lo_k", 64'(LO), 64'h22);
        run_op(4'd6, 32'h1234, 32'h0);
        check("mtlo_lo_k", 64'(LO), 64'h1234);
        check("mtlo_hi_k", 64'(HI), 64'h11);

        run_op(4'd5, 32'h0, 32'h0);
        run_op(4'd6, 32'hFFFF_FFFF, 32'h0);
        run_op(4'd8, 32'd1, 32'd1);
`ifdef MD_MADD_EN
        check("maddu_hi_k", 64'(HI), 64'h1);
        check("maddu_lo_k", 64'(LO), 64'h0);
`else
        check("maddu_hi_k", 64'(HI), 64'h0);
        check("maddu_lo_k", 64'(LO), 64'hFFFF_FFFF);
`endif

        for (int i = 0; i < 150; i++) begin
            run_op(4'($urandom_range(0, 12)), pick_operand(), pick_operand());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
